// File: rtl/osd_stm_pkg.sv
// Shared types and constants for the multi-channel software trace module.
package osd_stm_pkg;

    localparam logic [3:0]  STM_EVT_TYPE   = 4'h4;
    localparam logic [15:0] REG_CTRL       = 16'h0200;
    localparam logic [15:0] REG_CH_EN      = 16'h0201;
    localparam logic [15:0] REG_LOST_TOTAL = 16'h0202;
    localparam logic [15:0] REG_CHANNELS   = 16'h0203;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    typedef enum logic [3:0] {
        ST_IDLE, ST_HDR0, ST_HDR1, ST_HDR2, ST_TSL, ST_TSH, ST_TID, ST_VAL, ST_LOST
    } pkt_state_e;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {12'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/osd_stm_packetizer.sv
// Turns the head FIFO event into a DII trace packet, one flit per accepted cycle.
module osd_stm_packetizer
    import osd_stm_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       id,
    input  logic             fifo_empty,
    input  logic             fifo_more,
    input  logic [XLEN+68:0] entry,
    output logic             pop,
    output dii_flit          debug_out,
    input  logic             debug_out_ready
);
    localparam logic [3:0] LAST_WORD = 4'(XLEN / 16 - 1);

    typedef struct packed {
        logic            ovf;
        logic [15:0]     lost;
        logic [3:0]      channel;
        logic [XLEN-1:0] value;
        logic [15:0]     id;
        logic [31:0]     ts;
    } stm_event_t;

    stm_event_t ev;
    pkt_state_e state_q, state_d;
    logic [3:0] word_q, word_d;
    logic       accept;

    assign ev     = entry;
    assign accept = debug_out.valid & debug_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_HDR0;
            ST_HDR0: if (accept) state_d = ST_HDR1;
            ST_HDR1: if (accept) state_d = ST_HDR2;
            ST_HDR2: if (accept) state_d = ST_TSL;
            ST_TSL:  if (accept) state_d = ST_TSH;
            ST_TSH:  if (accept) state_d = ST_TID;
            ST_TID: begin
                if (accept) begin
                    state_d = ST_VAL;
                    word_d  = '0;
                end
            end
            ST_VAL: begin
                if (accept) begin
                    if (word_q != LAST_WORD) word_d = word_q + 4'd1;
                    else if (ev.ovf)         state_d = ST_LOST;
                    else                     state_d = fifo_more ? ST_HDR0 : ST_IDLE;
                end
            end
            ST_LOST: if (accept) state_d = fifo_more ? ST_HDR0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        debug_out       = '0;
        debug_out.valid = (state_q != ST_IDLE);
        case (state_q)
            ST_HDR1: debug_out.data = {6'b0, id};
            ST_HDR2: debug_out.data = {STM_EVT_TYPE, ev.ovf, 7'b0, ev.channel};
            ST_TSL:  debug_out.data = ev.ts[15:0];
            ST_TSH:  debug_out.data = ev.ts[31:16];
            ST_TID:  debug_out.data = ev.id;
            ST_VAL: begin
                debug_out.data = ev.value[{word_q, 4'b0} +: 16];
                debug_out.last = (word_q == LAST_WORD) & !ev.ovf;
            end
            ST_LOST: begin
                debug_out.data = ev.lost;
                debug_out.last = 1'b1;
            end
            default: debug_out.data = '0;
        endcase
        pop = debug_out.valid & debug_out_ready & debug_out.last;
    end

endmodule

// File: rtl/osd_stm_mc.sv
// Multi-channel software trace: per-channel capture, round-robin into an event FIFO, packetised to DII.
module osd_stm_mc
    import osd_stm_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned XLEN       = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [9:0]                 id,
    input  logic                       stall,
    input  logic [CHANNELS-1:0]        trace_valid,
    input  logic [CHANNELS*16-1:0]     trace_id,
    input  logic [CHANNELS*XLEN-1:0]   trace_value,
    input  logic                       reg_request,
    input  logic                       reg_write,
    input  logic [15:0]                reg_addr,
    input  logic [15:0]                reg_wdata,
    output logic                       reg_ack,
    output logic                       reg_err,
    output logic [15:0]                reg_rdata,
    output dii_flit                    debug_out,
    input  logic                       debug_out_ready
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef struct packed {
        logic            ovf;
        logic [15:0]     lost;
        logic [3:0]      channel;
        logic [XLEN-1:0] value;
        logic [15:0]     id;
        logic [31:0]     ts;
    } stm_event_t;

    typedef struct packed {
        logic [XLEN-1:0] value;
        logic [15:0]     id;
        logic [31:0]     ts;
    } hold_t;

    logic [31:0]         ts_q, ts_d;
    logic                ctrl_en_q, ctrl_en_d;
    logic [CHANNELS-1:0] ch_en_q, ch_en_d, hold_v_q, hold_v_d, drain;
    hold_t               hold_q [CHANNELS];
    hold_t               hold_d [CHANNELS];
    logic [15:0]         pend_lost_q, pend_lost_d, lost_total_q, lost_total_d;
    logic [CW-1:0]       last_grant_q, last_grant_d, grant_idx, idx;
    logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    stm_event_t          mem_q [FIFO_DEPTH];
    stm_event_t          wr_entry;
    logic                grant_v, fifo_wr, fifo_full, fifo_empty, pop, lost_clr;
    logic [4:0]          n_lost;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q         <= '0;
            ctrl_en_q    <= 1'b0;
            ch_en_q      <= '1;
            hold_v_q     <= '0;
            pend_lost_q  <= '0;
            lost_total_q <= '0;
            last_grant_q <= CW'(CHANNELS - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            ts_q         <= ts_d;
            ctrl_en_q    <= ctrl_en_d;
            ch_en_q      <= ch_en_d;
            hold_v_q     <= hold_v_d;
            pend_lost_q  <= pend_lost_d;
            lost_total_q <= lost_total_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by hold_v_q and the FIFO pointers.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
        if (fifo_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end

    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = CW'((int'(last_grant_q) + 1 + int'(i)) % int'(CHANNELS));
            if (!grant_v && hold_v_q[idx]) begin
                grant_v   = 1'b1;
                grant_idx = idx;
            end
        end
        fifo_wr      = grant_v & !fifo_full;
        drain        = fifo_wr ? (CHANNELS'(1) << grant_idx) : '0;
        last_grant_d = fifo_wr ? grant_idx : last_grant_q;
        wr_entry     = '{ovf: (pend_lost_q != '0), lost: pend_lost_q, channel: 4'(grant_idx),
                         value: hold_q[grant_idx].value, id: hold_q[grant_idx].id,
                         ts: hold_q[grant_idx].ts};
        wr_ptr_d     = wr_ptr_q + (AW+1)'(fifo_wr);
        rd_ptr_d     = rd_ptr_q + (AW+1)'(pop);
    end

    // A full holding register accepts a new event only if it drains in the same cycle.
    always_comb begin
        ts_d     = ts_q + 32'd1;
        hold_v_d = hold_v_q & ~drain;
        hold_d   = hold_q;
        n_lost   = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (trace_valid[c] && ctrl_en_q && ch_en_q[c] && !stall) begin
                if (hold_v_q[c] && !drain[c]) begin
                    n_lost = n_lost + 5'd1;
                end else begin
                    hold_v_d[c] = 1'b1;
                    hold_d[c]   = '{value: trace_value[c*XLEN +: XLEN], id: trace_id[c*16 +: 16], ts: ts_q};
                end
            end
        end
        pend_lost_d  = fifo_wr ? {11'b0, n_lost} : sat_add16(pend_lost_q, n_lost);
        lost_total_d = lost_clr ? '0 : sat_add16(lost_total_q, n_lost);
    end

    always_comb begin
        reg_ack   = 1'b0;
        reg_err   = 1'b0;
        reg_rdata = '0;
        ctrl_en_d = ctrl_en_q;
        ch_en_d   = ch_en_q;
        lost_clr  = 1'b0;
        if (reg_request) begin
            case (reg_addr)
                REG_CTRL: begin
                    reg_ack = 1'b1;
                    if (reg_write) ctrl_en_d = reg_wdata[0];
                    else           reg_rdata = {15'b0, ctrl_en_q};
                end
                REG_CH_EN: begin
                    reg_ack = 1'b1;
                    if (reg_write) ch_en_d   = reg_wdata[CHANNELS-1:0];
                    else           reg_rdata = 16'(ch_en_q);
                end
                REG_LOST_TOTAL: begin
                    reg_ack = 1'b1;
                    if (reg_write) lost_clr  = 1'b1;
                    else           reg_rdata = lost_total_q;
                end
                REG_CHANNELS: begin
                    if (reg_write) begin
                        reg_err = 1'b1;
                    end else begin
                        reg_ack   = 1'b1;
                        reg_rdata = 16'(CHANNELS);
                    end
                end
                default: reg_err = 1'b1;
            endcase
        end
    end

    osd_stm_packetizer #(
        .XLEN(XLEN)
    ) u_packetizer (
        .clk             (clk),
        .rst             (rst),
        .id              (id),
        .fifo_empty      (fifo_empty),
        .fifo_more       ((count > (AW+1)'(1)) | fifo_wr),
        .entry           (mem_q[rd_ptr_q[AW-1:0]]),
        .pop             (pop),
        .debug_out       (debug_out),
        .debug_out_ready (debug_out_ready)
    );

endmodule

// File: tb/tb_osd_stm_mc.sv
// Directed self-checking bench for osd_stm_mc (4 channels, 64-bit values, 8-entry FIFO).
module tb_osd_stm_mc;
    import osd_stm_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [9:0]   id = 10'h155;
    logic         stall = 1'b0;
    logic [3:0]   trace_valid = '0;
    logic [63:0]  trace_id = '0;
    logic [255:0] trace_value = '0;
    logic         reg_request = 1'b0;
    logic         reg_write = 1'b0;
    logic [15:0]  reg_addr = '0;
    logic [15:0]  reg_wdata = '0;
    logic         reg_ack, reg_err;
    logic [15:0]  reg_rdata;
    dii_flit      debug_out;
    logic         debug_out_ready = 1'b0;

    int           total = 0;
    int           bad = 0;
    logic [31:0]  tb_ts;
    logic [15:0]  fl_d [0:127];
    logic         fl_l [0:127];
    logic [15:0]  rd;
    logic         ack, err;
    int           vcnt;

    always #5 clk = ~clk;

    // Reference timestamp: zero in reset, +1 on every clock after.
    always @(posedge clk or posedge rst)
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 32'd1;

    osd_stm_mc #(
        .CHANNELS(4),
        .XLEN(64),
        .FIFO_DEPTH(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id              (id),
        .stall           (stall),
        .trace_valid     (trace_valid),
        .trace_id        (trace_id),
        .trace_value     (trace_value),
        .reg_request     (reg_request),
        .reg_write       (reg_write),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_ack         (reg_ack),
        .reg_err         (reg_err),
        .reg_rdata       (reg_rdata),
        .debug_out       (debug_out),
        .debug_out_ready (debug_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reg_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        reg_request = 1'b1;
        reg_write   = wr;
        reg_addr    = addr;
        reg_wdata   = wdata;
        @(negedge clk);
        ack = reg_ack;
        err = reg_err;
        rd  = reg_rdata;
        @(posedge clk);
        #1;
        reg_request = 1'b0;
        reg_write   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic collect(input int n);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        debug_out_ready = 1'b1;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            if (debug_out.valid) begin
                fl_d[got] = debug_out.data;
                fl_l[got] = debug_out.last;
                got++;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        chk("collect_count", got, n);
    endtask

    task automatic pulse(input logic [3:0] v);
        trace_valid = v;
        @(posedge clk);
        #1;
        trace_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp1 [0:9];
        int          guard;
        exp1 = '{16'h0000, 16'h0155, 16'h4002, 16'h0010, 16'h0000,
                 16'h0042, 16'h7788, 16'h5566, 16'h3344, 16'h1122};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_valid", debug_out.valid, 1'b0);
        chk("rst_ack", reg_ack, 1'b0);
        @(posedge clk);
        #1;
        reg_access(1'b0, REG_CTRL, '0);       chk("rst_ctrl", rd, 16'h0000);
        reg_access(1'b0, REG_CH_EN, '0);      chk("rst_chen", rd, 16'h000F);
        reg_access(1'b0, REG_LOST_TOTAL, '0); chk("rst_lost", rd, 16'h0000);
        reg_access(1'b1, REG_CTRL, 16'h0001); chk("ctrl_wr_ack", ack, 1'b1);

        // Single event on ch2 captured at timestamp 0x10
        trace_id[2*16 +: 16]    = 16'h0042;
        trace_value[2*64 +: 64] = 64'h1122334455667788;
        guard = 0;
        while (tb_ts != 32'h10 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("ts_wait", tb_ts, 32'h10);
        pulse(4'b0100);
        collect(10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t1_flit%0d", i), fl_d[i], exp1[i]);
            chk($sformatf("t1_last%0d", i), fl_l[i], (i == 9));
        end

        // All four channels in one cycle: served in order 0..3
        do_reset();
        reg_access(1'b1, REG_CTRL, 16'h0001);
        for (int c = 0; c < 4; c++) begin
            trace_id[c*16 +: 16]    = 16'h0100 + 16'(c);
            trace_value[c*64 +: 64] = {4{16'h1000 + 16'(c)}};
        end
        pulse(4'b1111);
        collect(40);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("t2_hdr2_p%0d", p), fl_d[p*10+2], 16'h4000 + 16'(p));
            chk($sformatf("t2_tid_p%0d", p), fl_d[p*10+5], 16'h0100 + 16'(p));
            chk($sformatf("t2_val_p%0d", p), fl_d[p*10+6], 16'h1000 + 16'(p));
            chk($sformatf("t2_last_p%0d", p), fl_l[p*10+9], 1'b1);
        end
        reg_access(1'b0, REG_LOST_TOTAL, '0); chk("t2_lost_total", rd, 16'h0000);

        // Back-pressure: 12 events on ch0 into an 8-deep FIFO lose 3
        debug_out_ready         = 1'b0;
        trace_id[15:0]          = 16'h0007;
        trace_value[63:0]       = 64'hAAAABBBBCCCCDDDD;
        trace_valid             = 4'b0001;
        repeat (12) @(posedge clk);
        #1;
        trace_valid = '0;
        @(negedge clk);
        chk("t3_hold_valid", debug_out.valid, 1'b1);
        chk("t3_hold_data", debug_out.data, 16'h0000);
        repeat (3) @(negedge clk);
        chk("t3_stable_valid", debug_out.valid, 1'b1);
        chk("t3_stable_data", debug_out.data, 16'h0000);
        @(posedge clk);
        #1;
        reg_access(1'b0, REG_LOST_TOTAL, '0); chk("t3_lost_total", rd, 16'h0003);
        collect(91);
        for (int p = 0; p < 8; p++) begin
            chk($sformatf("t3_hdr2_p%0d", p), fl_d[p*10+2], 16'h4000);
            chk($sformatf("t3_last_p%0d", p), fl_l[p*10+9], 1'b1);
        end
        chk("t3_ovf_hdr2", fl_d[82], 16'h4800);
        chk("t3_ovf_tid", fl_d[85], 16'h0007);
        chk("t3_ovf_val3", fl_d[89], 16'hAAAA);
        chk("t3_ovf_val3_last", fl_l[89], 1'b0);
        chk("t3_lost_flit", fl_d[90], 16'h0003);
        chk("t3_lost_last", fl_l[90], 1'b1);
        reg_access(1'b1, REG_LOST_TOTAL, 16'h1234); chk("t3_clr_ack", ack, 1'b1);
        reg_access(1'b0, REG_LOST_TOTAL, '0);       chk("t3_clr_read", rd, 16'h0000);

        // Channel mask 0x5: ch1/ch3 ignored, ch0 passes
        reg_access(1'b1, REG_CH_EN, 16'h0005);
        reg_access(1'b0, REG_CH_EN, '0); chk("t4_chen_read", rd, 16'h0005);
        debug_out_ready = 1'b1;
        pulse(4'b1010);
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (debug_out.valid) vcnt++;
        end
        chk("t4_masked_flits", vcnt, 0);
        @(posedge clk);
        #1;
        trace_id[15:0] = 16'h0033;
        pulse(4'b0001);
        collect(10);
        chk("t4_hdr2", fl_d[2], 16'h4000);
        chk("t4_tid", fl_d[5], 16'h0033);

        // Reset while the first VAL flit is on the bus
        debug_out_ready   = 1'b0;
        trace_id[15:0]    = 16'h0042;
        trace_value[63:0] = 64'h1122334455667788;
        pulse(4'b0001);
        guard = 0;
        while (!debug_out.valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("t5_pkt_start", debug_out.valid, 1'b1);
        @(posedge clk);
        #1;
        debug_out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        debug_out_ready = 1'b0;
        @(negedge clk);
        chk("t5_val_valid", debug_out.valid, 1'b1);
        chk("t5_val_data", debug_out.data, 16'h7788);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", debug_out.valid, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        debug_out_ready = 1'b1;
        vcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (debug_out.valid) vcnt++;
        end
        chk("t5_fifo_empty", vcnt, 0);
        @(posedge clk);
        #1;
        reg_access(1'b0, REG_CH_EN, '0); chk("t5_chen_read", rd, 16'h000F);
        reg_access(1'b0, REG_CTRL, '0);  chk("t5_ctrl_read", rd, 16'h0000);

        // Register error paths
        reg_access(1'b0, 16'h0300, '0);
        chk("t6_bad_addr_err", err, 1'b1);
        chk("t6_bad_addr_ack", ack, 1'b0);
        reg_access(1'b1, REG_CHANNELS, 16'h0009);
        chk("t6_ro_write_err", err, 1'b1);
        chk("t6_ro_write_ack", ack, 1'b0);
        reg_access(1'b0, REG_CHANNELS, '0);
        chk("t6_channels_ack", ack, 1'b1);
        chk("t6_channels_val", rd, 16'h0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/osd_stm_mc.md
Name: osd_stm_mc

Overview:
Multi-channel successor to the single-port software trace module. It accepts up to CHANNELS independent trace ports, each with a one-entry holding register. Events are timestamped at capture, arbitrated round-robin into an event FIFO, and packetised into DII flits toward the debug interconnect. Per-channel enable masking and lost-event accounting are configured through the standard register interface, which the instantiating wrapper connects to osd_regaccess_layer.

Parameters:
CHANNELS, 4, number of trace ports; 1..16.
XLEN, 64, trace value width; a multiple of 16, 16..128.
FIFO_DEPTH, 8, event FIFO entries; a power of two, at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
id  in  10  module address, used as packet source
stall  in  1  global stall from the register layer; suppresses capture
trace_valid  in  CHANNELS  per-channel event strobe
trace_id  in  CHANNELS*16  per-channel event id, channel c at bits [16c+15:16c]
trace_value  in  CHANNELS*XLEN  per-channel payload, packed the same way
reg_request, reg_write  in  1,1  register access strobe and direction
reg_addr  in  16  register address
reg_wdata  in  16  write data
reg_ack, reg_err  out  1,1  access response
reg_rdata  out  16  read data
debug_out  out  dii_flit  trace packet stream
debug_out_ready  in  1  downstream ready

Behaviour:
- Reset (async): all outputs 0, so debug_out.valid=0 at once. Holding registers empty, FIFO empty, timestamp 0, CTRL=0, CH_EN all ones, lost counters 0. A partially sent packet is dropped.
- Timestamp: free-running 32-bit counter from osd_timestamp; wraps 0xFFFFFFFF->0.
- Capture: channel c is captured when trace_valid[c] & CTRL.en & CH_EN[c] & !stall. The captured entry is {value, id, timestamp of that cycle}, stored in hold[c] at the next edge.
  - If hold[c] is full and is not drained in the same cycle, the event is lost.
  - If hold[c] drains in the same cycle, the new event is accepted (no loss).
- Arbiter: each cycle, when the FIFO is not full, writes one occupied hold entry to the FIFO. Pointer search starts at (last granted + 1) mod CHANNELS. Capture-to-FIFO latency is 1 cycle when uncontended.
- Lost accounting:
  - pend_lost: 16-bit, saturating at 0xFFFF, incremented by the number of losses each cycle.
  - On a FIFO write, the entry takes a snapshot of pend_lost and its ovf flag = (pend_lost!=0). pend_lost then becomes the count of losses in that same cycle.
  - LOST_TOTAL: 16-bit saturating running sum of all losses.
- FIFO entry: {ovf, lost[15:0], channel[3:0], value, id, ts}, built from osd_fifo with DEPTH=FIFO_DEPTH.
- Packetiser FSM states: IDLE, HDR0, HDR1, HDR2, TSL, TSH, TID, VAL, LOST.
  - IDLE moves to HDR0 when the FIFO is non-empty. Each state advances only on debug_out.valid & debug_out_ready.
  - Flit data, in order:
    - HDR0 = 0x0000
    - HDR1 = {6'b0, id}
    - HDR2 = {4'h4, ovf, 7'b0, channel}
    - TSL = ts[15:0], TSH = ts[31:16]
    - TID = id field
    - VAL = XLEN/16 flits, least-significant word first
    - LOST flit only when ovf=1
  - last=1 on the final flit. The FIFO is popped on acceptance of the last flit. Valid and data are held stable while ready=0.
  - Back-to-back packets: no idle cycle after last when the FIFO is non-empty.
- Registers (one-cycle response):
  - reg_ack=1 on the request cycle for a valid address; reg_err=1 otherwise (including writes to read-only registers).
  - 0x200 CTRL, RW, bit0 = en.
  - 0x201 CH_EN, RW, bits [CHANNELS-1:0]; upper bits read 0.
  - 0x202 LOST_TOTAL, RO; a write of any value clears it and returns ack.
  - 0x203 CHANNELS, RO, returns the CHANNELS parameter.
- Clearing CTRL.en mid-packet: the packet in flight completes; entries already in the FIFO are still sent.

Decomposition:
- Shared package osd_stm_pkg:
  - constants STM_EVT_TYPE=4'h4 and the register addresses 0x200..0x203
  - typedef stm_event_t {ovf, lost, channel, value, id, ts}; because it depends on XLEN, it is a localparam struct built inside the module.
- New sub-module osd_stm_packetizer: FIFO-to-dii_flit FSM, parametrised by XLEN.
- Existing blocks reused: osd_timestamp, osd_fifo.

Test Plan:
- CTRL.en=1, event on ch2 (id 0x0042, value 0x1122334455667788, ts 0x10) with ready=1 -> flits 0000, {id}, 4002, 0010, 0000, 0042, 7788, 5566, 3344, 1122; last on the 10th flit; no LOST flit.
- All 4 channels valid in the same cycle -> packets emitted for ch0,1,2,3 in that order; LOST_TOTAL=0.
- ready held 0, ch0 valid for 12 consecutive cycles with DEPTH=8 -> lost events counted. Next released packet has ovf=1 and a LOST flit equal to the loss count; LOST_TOTAL matches. Writing 0x202 -> reads 0.
- CH_EN=0x0005, events on ch1 and ch3 -> no packets; ch0 event -> packet emitted.
- rst asserted while the VAL flit is being sent -> debug_out.valid drops in the same cycle; after release the FIFO is empty and CH_EN reads 0x000F.
- Read 0x300 -> reg_err=1. Write 0x203 -> reg_err=1. Read 0x203 -> 0x0004.
